data_memory_pipe: RTL and testbench

//  Clocked, parametrised byte-addressed big-endian data memory for the PPU memory stage.

---
 rtl/data_mem_pkg.sv | 47 ++++
 rtl/data_mem_array.sv | 34 +++
 rtl/data_memory_pipe.sv | 111 +++++++++++
 tb/tb_data_memory_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the PPU memory-stage data memory.
//   size_e    : access size encodings (BYTE/HALFWORD/WORD/ILLEGAL)
//   rsp_t     : response record {write, error, data} carried down the read pipe
//   misaligned: alignment check for a legal size against the low address bits
//   ext_load  : right-justify and sign/zero-extend a big-endian 4-byte fetch
package data_mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef struct packed {
    logic              write;
    logic              error;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (size)
      SZ_HALF: r = addr_lo[0];
      SZ_WORD: r = (addr_lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // rbytes holds M[A] in [31:24] down to M[A+3] in [7:0].
  function automatic logic [DATA_W-1:0] ext_load(input logic [1:0] size, input logic sext,
                                                 input logic [DATA_W-1:0] rbytes);
    logic [DATA_W-1:0] r;
    case (size)
      SZ_BYTE: r = {{24{sext & rbytes[31]}}, rbytes[31:24]};
      SZ_HALF: r = {{16{sext & rbytes[31]}}, rbytes[31:16]};
      default: r = rbytes;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-wide storage with four byte-lane write enables and an asynchronous
// 4-byte read window starting at addr.
//   clk   : write clock
//   we    : lane enables, we[3] -> M[addr], we[0] -> M[addr+3]
//   addr  : byte address of the window
//   wdata : lane data, [31:24] -> M[addr]
//   rdata : {M[addr], M[addr+1], M[addr+2], M[addr+3]}
// Contents are never reset.
module data_mem_array #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // Lane writes; bytes past the top of memory wrap but are never enabled for aligned accesses.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) mem[addr + ADDR_W'(i)] <= wdata[31-8*i -: 8];
    end
  end

  // Asynchronous read of the 4-byte window.
  for (genvar g = 0; g < 4; g++) begin : g_rd
    assign rdata[31-8*g -: 8] = mem[addr + ADDR_W'(g)];
  end

endmodule

// File: rtl/data_memory_pipe.sv
// Big-endian byte-addressed data memory for the PPU memory stage.
// Requests are checked for legality and performed on the accept edge; the
// response record then travels a READ_LAT-deep pipe that stalls as a whole
// under response backpressure.
//   Clk, Reset          : clock, synchronous active-high reset
//   ReqValid/ReqReady   : request handshake
//   ReadWrite, SignExt  : store/load select, load sign-extension
//   Size, Address       : access size and byte address (MSB at Address)
//   DataIn              : right-justified store data
//   RspValid/RspReady   : response handshake
//   DataOut, RspWrite, Error : response payload
module data_memory_pipe
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DEPTH    = 2**ADDR_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReadWrite,
  input  logic              SignExt,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [31:0]       DataOut,
  output logic              RspWrite,
  output logic              Error
);

  logic                advance;
  logic                accept;
  logic                illegal;
  logic [3:0]          we;
  logic [31:0]         wdata;
  logic [31:0]         rdata;
  rsp_t                new_rsp;
  rsp_t                pipe_q [READ_LAT];
  logic [READ_LAT-1:0] vld_q;

  assign advance  = !RspValid || RspReady;
  assign ReqReady = advance && !Reset;
  assign accept   = ReqValid && ReqReady;
  assign illegal  = (Size == SZ_ILLEGAL) || misaligned(Size, Address[1:0]);

  // Store lane enables and big-endian lane placement; only legal accepted stores write.
  always_comb begin
    we    = 4'b0000;
    wdata = DataIn;
    if (accept && ReadWrite && !illegal) begin
      case (Size)
        SZ_BYTE: begin
          we    = 4'b1000;
          wdata = {DataIn[7:0], 24'h0};
        end
        SZ_HALF: begin
          we    = 4'b1100;
          wdata = {DataIn[15:0], 16'h0};
        end
        default: begin
          we    = 4'b1111;
          wdata = DataIn;
        end
      endcase
    end
  end

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (Clk),
    .we    (we),
    .addr  (Address),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Response record formed at accept time; stores and errors carry zero data.
  always_comb begin
    new_rsp       = '0;
    new_rsp.write = ReadWrite;
    new_rsp.error = illegal;
    if (!ReadWrite && !illegal) new_rsp.data = ext_load(Size, SignExt, rdata);
  end

  // Response shift pipe; bubbles carry a zero record so outputs stay clean when idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) pipe_q[i] <= '0;
    end else if (advance) begin
      vld_q[0]  <= accept;
      pipe_q[0] <= accept ? new_rsp : '0;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign RspValid = vld_q[READ_LAT-1];
  assign DataOut  = pipe_q[READ_LAT-1].data;
  assign RspWrite = pipe_q[READ_LAT-1].write;
  assign Error    = pipe_q[READ_LAT-1].error;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: a READ_LAT=1 instance for directed vectors and
// streaming against a byte-array model, and a READ_LAT=3 instance for
// backpressure and reset-while-busy sequences.
module tb_data_memory_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_rw, a_sext, a_rvalid, a_rready, a_rwrite, a_err;
  logic [1:0]  a_size;
  logic [8:0]  a_addr;
  logic [31:0] a_din, a_dout;

  logic        b_valid, b_ready, b_rw, b_sext, b_rvalid, b_rready, b_rwrite, b_err;
  logic [1:0]  b_size;
  logic [8:0]  b_addr;
  logic [31:0] b_din, b_dout;

  data_memory_pipe #(.ADDR_W(9), .READ_LAT(1)) u_a (
    .Clk(clk), .Reset(rst), .ReqValid(a_valid), .ReqReady(a_ready), .ReadWrite(a_rw),
    .SignExt(a_sext), .Size(a_size), .Address(a_addr), .DataIn(a_din), .RspValid(a_rvalid),
    .RspReady(a_rready), .DataOut(a_dout), .RspWrite(a_rwrite), .Error(a_err)
  );

  data_memory_pipe #(.ADDR_W(9), .READ_LAT(3)) u_b (
    .Clk(clk), .Reset(rst), .ReqValid(b_valid), .ReqReady(b_ready), .ReadWrite(b_rw),
    .SignExt(b_sext), .Size(b_size), .Address(b_addr), .DataIn(b_din), .RspValid(b_rvalid),
    .RspReady(b_rready), .DataOut(b_dout), .RspWrite(b_rwrite), .Error(b_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic        sext;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic        exp_write;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rw, input logic sext, input logic [1:0] size,
                              input logic [8:0] addr, input logic [31:0] din,
                              input logic [31:0] ed, input logic ew, input logic ee);
    vec_t v;
    v.rw = rw; v.sext = sext; v.size = size; v.addr = addr; v.din = din;
    v.exp_data = ed; v.exp_write = ew; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  // One request on instance A; with READ_LAT=1 the response is visible right after the accept edge.
  task automatic a_xfer(input vec_t v, input string name);
    @(negedge clk);
    a_valid = 1'b1; a_rw = v.rw; a_sext = v.sext; a_size = v.size; a_addr = v.addr; a_din = v.din;
    #1;
    chk({name, ".ready"}, 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk({name, ".rvalid"}, 32'(a_rvalid), 32'd1);
    chk({name, ".data"},   a_dout,         v.exp_data);
    chk({name, ".write"},  32'(a_rwrite), 32'(v.exp_write));
    chk({name, ".error"},  32'(a_err),    32'(v.exp_err));
  endtask

  // Reference byte store for streaming.
  logic [7:0] mdl [512];

  function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic sext, input logic [8:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    if (size == 2'b00) begin
      b = mdl[a];
      return (sext && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
    end else if (size == 2'b01) begin
      h = {mdl[a], mdl[a+1]};
      return (sext && h[15]) ? {16'hFFFF, h} : {16'h0, h};
    end
    return {mdl[a], mdl[a+1], mdl[a+2], mdl[a+3]};
  endfunction

  function automatic void mdl_store(input logic [1:0] size, input logic [8:0] a, input logic [31:0] d);
    if (size == 2'b00) mdl[a] = d[7:0];
    else if (size == 2'b01) begin
      mdl[a] = d[15:8]; mdl[a+1] = d[7:0];
    end else begin
      mdl[a] = d[31:24]; mdl[a+1] = d[23:16]; mdl[a+2] = d[15:8]; mdl[a+3] = d[7:0];
    end
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_val [5];
    logic [31:0] got [$];
    logic        stalled_prev, will_accept, saw_ready_low;
    logic [31:0] prev_data;
    logic        prev_w, prev_e;
    int          issued, extra;
    logic [31:0] rd;
    logic        rd_seen;
    vec_t        v;

    rst = 1'b1;
    a_valid = 0; a_rw = 0; a_sext = 0; a_size = 0; a_addr = 0; a_din = 0; a_rready = 1;
    b_valid = 0; b_rw = 0; b_sext = 0; b_size = 0; b_addr = 0; b_din = 0; b_rready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.a_ready",  32'(a_ready),  32'd0);
    chk("rst.a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst.a_data",   a_dout,        32'd0);
    chk("rst.a_write",  32'(a_rwrite), 32'd0);
    chk("rst.a_error",  32'(a_err),    32'd0);
    chk("rst.b_rvalid", 32'(b_rvalid), 32'd0);
    rst = 1'b0;

    // Directed vectors: rw, sext, size, addr, din, exp data, exp write, exp error
    add(1, 0, 2'b10, 9'h010, 32'hDEADBEEF, 32'h0,        1, 0);
    add(0, 0, 2'b10, 9'h010, 32'h0,        32'hDEADBEEF, 0, 0);
    add(0, 1, 2'b00, 9'h013, 32'h0,        32'hFFFFFFEF, 0, 0);
    add(0, 0, 2'b01, 9'h010, 32'h0,        32'h0000DEAD, 0, 0);
    add(0, 1, 2'b01, 9'h010, 32'h0,        32'hFFFFDEAD, 0, 0);
    add(1, 0, 2'b10, 9'h012, 32'h11223344, 32'h0,        1, 1);
    add(0, 0, 2'b10, 9'h010, 32'h0,        32'hDEADBEEF, 0, 0);
    add(0, 0, 2'b11, 9'h010, 32'h0,        32'h0,        0, 1);
    add(1, 0, 2'b11, 9'h010, 32'h55555555, 32'h0,        1, 1);
    add(0, 0, 2'b10, 9'h010, 32'h0,        32'hDEADBEEF, 0, 0);
    add(0, 0, 2'b01, 9'h011, 32'h0,        32'h0,        0, 1);
    add(1, 0, 2'b00, 9'h011, 32'h12345680, 32'h0,        1, 0);
    add(0, 0, 2'b10, 9'h010, 32'h0,        32'hDE80BEEF, 0, 0);
    add(0, 0, 2'b00, 9'h011, 32'h0,        32'h00000080, 0, 0);
    add(0, 1, 2'b00, 9'h011, 32'h0,        32'hFFFFFF80, 0, 0);
    add(1, 0, 2'b01, 9'h012, 32'hFFFF1234, 32'h0,        1, 0);
    add(0, 1, 2'b10, 9'h010, 32'h0,        32'hDE801234, 0, 0);
    add(0, 1, 2'b01, 9'h012, 32'h0,        32'h00001234, 0, 0);
    add(1, 0, 2'b10, 9'h1FC, 32'hCAFEF00D, 32'h0,        1, 0);
    add(0, 0, 2'b10, 9'h1FC, 32'h0,        32'hCAFEF00D, 0, 0);
    add(1, 0, 2'b00, 9'h1FF, 32'h0000007F, 32'h0,        1, 0);
    add(0, 1, 2'b00, 9'h1FF, 32'h0,        32'h0000007F, 0, 0);
    add(0, 1, 2'b00, 9'h1FE, 32'h0,        32'hFFFFFFF0, 0, 0);
    add(0, 0, 2'b10, 9'h1FC, 32'h0,        32'hCAFEF07F, 0, 0);
    for (int i = 0; i < vecs.size(); i++) a_xfer(vecs[i], $sformatf("vec%0d", i));

    // Streaming: preload 0x100..0x13F, then 64 random legal accesses back to back
    for (int w = 0; w < 16; w++) begin
      v.rw = 1; v.sext = 0; v.size = 2'b10; v.addr = 9'(32'h100 + 4 * w); v.din = $urandom;
      v.exp_data = 0; v.exp_write = 1; v.exp_err = 0;
      mdl_store(v.size, v.addr, v.din);
      a_xfer(v, $sformatf("pre%0d", w));
    end
    for (int k = 0; k < 64; k++) begin
      v.size = 2'($urandom_range(0, 2));
      v.addr = 9'(32'h100 + $urandom_range(0, 63));
      if (v.size == 2'b01) v.addr[0] = 1'b0;
      if (v.size == 2'b10) v.addr[1:0] = 2'b00;
      v.rw = 1'($urandom_range(0, 1));
      v.sext = 1'($urandom_range(0, 1));
      v.din = $urandom;
      v.exp_write = v.rw; v.exp_err = 0;
      v.exp_data = v.rw ? 32'h0 : mdl_load(v.size, v.sext, v.addr);
      if (v.rw) mdl_store(v.size, v.addr, v.din);
      a_xfer(v, $sformatf("strm%0d", k));
    end

    // Backpressure on READ_LAT=3: preload five words
    for (int i = 0; i < 5; i++) bp_val[i] = 32'hA0B0C000 + 32'(i * 32'h01010101);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_valid = 1; b_rw = 1; b_size = 2'b10; b_addr = 9'(32'h40 + 4 * i); b_din = bp_val[i];
      @(posedge clk);
    end
    @(negedge clk);
    b_valid = 0;
    repeat (5) @(posedge clk);

    // Five back-to-back loads with RspReady low for cycles 2..6
    stalled_prev = 0; saw_ready_low = 0; issued = 0;
    prev_data = 0; prev_w = 0; prev_e = 0;
    for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
      @(negedge clk);
      b_rready = !(cyc >= 2 && cyc <= 6);
      if (issued < 5) begin
        b_valid = 1; b_rw = 0; b_sext = 0; b_size = 2'b10; b_addr = 9'(32'h40 + 4 * issued);
      end else b_valid = 0;
      #1;
      if (stalled_prev) begin
        chk($sformatf("bp.hold_valid%0d", cyc), 32'(b_rvalid), 32'd1);
        chk($sformatf("bp.hold_data%0d", cyc),  b_dout,        prev_data);
        chk($sformatf("bp.hold_flags%0d", cyc), {30'd0, b_rwrite, b_err}, {30'd0, prev_w, prev_e});
      end
      if (b_valid && !b_ready) saw_ready_low = 1;
      if (b_rvalid && b_rready) got.push_back(b_dout);
      stalled_prev = b_rvalid && !b_rready;
      prev_data = b_dout; prev_w = b_rwrite; prev_e = b_err;
      will_accept = b_valid && b_ready;
      @(posedge clk);
      if (will_accept) issued++;
    end
    @(negedge clk);
    b_valid = 0; b_rready = 1;
    chk("bp.ready_dropped", 32'(saw_ready_low), 32'd1);
    chk("bp.count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++) chk($sformatf("bp.order%0d", i), got[i], bp_val[i]);
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (b_rvalid) extra++;
    end
    chk("bp.no_duplicate", 32'(extra), 32'd0);

    // Reset with two loads in flight and a store presented
    @(negedge clk);
    b_valid = 1; b_rw = 0; b_size = 2'b10; b_addr = 9'h040;
    @(negedge clk);
    b_addr = 9'h044;
    @(negedge clk);
    rst = 1; b_rw = 1; b_addr = 9'h048; b_din = 32'h99999999;
    #1;
    chk("rst_mid.ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid.rvalid", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    rst = 0; b_valid = 0;
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (b_rvalid) extra++;
    end
    chk("rst_mid.no_rsp", 32'(extra), 32'd0);
    @(negedge clk);
    b_valid = 1; b_rw = 0; b_size = 2'b10; b_addr = 9'h048;
    @(posedge clk);
    @(negedge clk);
    b_valid = 0;
    rd = 32'h0; rd_seen = 0;
    for (int c = 0; c < 10 && !rd_seen; c++) begin
      @(posedge clk);
      #1;
      if (b_rvalid) begin
        rd = b_dout; rd_seen = 1;
      end
    end
    chk("rst_mid.rsp_seen", 32'(rd_seen), 32'd1);
    chk("rst_mid.old_value", rd, bp_val[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
